// File: rtl/lcd_ctrl.sv
// HD44780-style parallel LCD write controller.
// Runs the power-on init sequence, then writes one CPU byte at a time with fixed setup, EN, hold and execution timing.
module lcd_ctrl #(
  parameter int unsigned POWERUP_CYC = 750000,
  parameter int unsigned SETUP_CYC   = 4,
  parameter int unsigned EN_CYC      = 12,
  parameter int unsigned HOLD_CYC    = 4,
  parameter int unsigned CMD_CYC     = 2500,
  parameter int unsigned CLR_CYC     = 82000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_valid_i,
  input  logic       req_rs_i,
  input  logic [7:0] req_data_i,
  output logic       req_ready_o,
  output logic       init_done_o,
  output logic [7:0] lcd_data_o,
  output logic       lcd_rs_o,
  output logic       lcd_rw_o,
  output logic       lcd_en_o,
  output logic       lcd_on_o,
  output logic [2:0] dbg_state_o
);

  // Handshake: a byte transfers on every rising edge where req_valid_i and
  // req_ready_o are both 1. req_ready_o is registered and is only high in
  // IDLE after init; req_valid_i while req_ready_o is low is ignored.

  localparam int unsigned MAX_A   = (POWERUP_CYC > SETUP_CYC) ? POWERUP_CYC : SETUP_CYC;
  localparam int unsigned MAX_B   = (EN_CYC > HOLD_CYC) ? EN_CYC : HOLD_CYC;
  localparam int unsigned MAX_C   = (CMD_CYC > CLR_CYC) ? CMD_CYC : CLR_CYC;
  localparam int unsigned MAX_AB  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned MAX_CYC = (MAX_AB > MAX_C) ? MAX_AB : MAX_C;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);

  localparam logic [CW-1:0] PWR_LAST   = CW'(POWERUP_CYC - 1);
  localparam logic [CW-1:0] SETUP_LAST = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] EN_LAST    = CW'(EN_CYC - 1);
  localparam logic [CW-1:0] HOLD_LAST  = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] CMD_LAST   = CW'(CMD_CYC - 1);
  localparam logic [CW-1:0] CLR_LAST   = CW'(CLR_CYC - 1);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);

  typedef enum logic [2:0] {
    PWRUP     = 3'd0,
    INIT_LOAD = 3'd1,
    SETUP     = 3'd2,
    PULSE     = 3'd3,
    HOLD      = 3'd4,
    WAIT      = 3'd5,
    IDLE      = 3'd6
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    idx_q, idx_d;
  logic          done_q, done_d;
  logic          ready_q, ready_d;
  logic          en_q, en_d;
  logic          rs_q, rs_d;
  logic [7:0]    data_q, data_d;
  logic          on_q, on_d;
  logic [CW-1:0] wait_last;

  // Function set 8-bit/2-line, display on, clear, entry mode increment.
  function automatic logic [7:0] rom_byte(input logic [1:0] idx);
    case (idx)
      2'd0:    rom_byte = 8'h38;
      2'd1:    rom_byte = 8'h0C;
      2'd2:    rom_byte = 8'h01;
      default: rom_byte = 8'h06;
    endcase
  endfunction

  // Clear display and return home need the long execution wait.
  assign wait_last = (!rs_q && (data_q == 8'h01 || data_q == 8'h02)) ? CLR_LAST : CMD_LAST;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CNT_ONE;
    idx_d   = idx_q;
    done_d  = done_q;
    ready_d = ready_q;
    en_d    = en_q;
    rs_d    = rs_q;
    data_d  = data_q;
    on_d    = 1'b1;
    case (state_q)
      PWRUP: begin
        // INIT_LOAD is folded into this exit so it costs no cycle.
        if (cnt_q == PWR_LAST) begin
          state_d = SETUP;
          cnt_d   = '0;
          rs_d    = 1'b0;
          data_d  = rom_byte(idx_q);
        end
      end
      INIT_LOAD: begin
        state_d = SETUP;
        cnt_d   = '0;
        rs_d    = 1'b0;
        data_d  = rom_byte(idx_q);
      end
      SETUP: begin
        if (cnt_q == SETUP_LAST) begin
          state_d = PULSE;
          cnt_d   = '0;
          en_d    = 1'b1;
        end
      end
      PULSE: begin
        if (cnt_q == EN_LAST) begin
          state_d = HOLD;
          cnt_d   = '0;
          en_d    = 1'b0;
        end
      end
      HOLD: begin
        if (cnt_q == HOLD_LAST) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (cnt_q == wait_last) begin
          cnt_d = '0;
          if (!done_q && idx_q != 2'd3) begin
            idx_d   = idx_q + 2'd1;
            rs_d    = 1'b0;
            data_d  = rom_byte(idx_q + 2'd1);
            state_d = SETUP;
          end else begin
            done_d  = 1'b1;
            ready_d = 1'b1;
            state_d = IDLE;
          end
        end
      end
      IDLE: begin
        cnt_d = '0;
        if (ready_q && req_valid_i) begin
          rs_d    = req_rs_i;
          data_d  = req_data_i;
          ready_d = 1'b0;
          state_d = SETUP;
        end
      end
      default: begin
        state_d = PWRUP;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= PWRUP;
      cnt_q   <= '0;
      idx_q   <= 2'd0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
      en_q    <= 1'b0;
      rs_q    <= 1'b0;
      data_q  <= 8'h00;
      on_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      ready_q <= ready_d;
      en_q    <= en_d;
      rs_q    <= rs_d;
      data_q  <= data_d;
      on_q    <= on_d;
    end
  end

  assign req_ready_o = ready_q;
  assign init_done_o = done_q;
  assign lcd_data_o  = data_q;
  assign lcd_rs_o    = rs_q;
  assign lcd_rw_o    = 1'b0;
  assign lcd_en_o    = en_q;
  assign lcd_on_o    = on_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/lcd_ctrl.md
LCD_CTRL -- requirements
Module: lcd_ctrl

Interface
REQ-001 Parameter POWERUP_CYC, default 750000: power-on wait in clocks (15 ms at 50 MHz).
REQ-002 Parameter SETUP_CYC, default 4: RS/DATA setup before EN rises, in clocks.
REQ-003 Parameter EN_CYC, default 12: EN high width, in clocks.
REQ-004 Parameter HOLD_CYC, default 4: EN low hold after the falling edge, in clocks.
REQ-005 Parameter CMD_CYC, default 2500: execution wait for a normal command or data byte, in clocks.
REQ-006 Parameter CLR_CYC, default 82000: execution wait for command bytes 0x01 and 0x02, in clocks.
REQ-007 Every parameter SHALL be ≥1, and counters SHALL be sized to the largest parameter.
REQ-008 clk_i  in  1  single clock, 50 MHz.
REQ-009 rst_i  in  1  reset, synchronous, active-high.
REQ-010 req_valid_i  in  1  CPU request to write one byte.
REQ-011 req_rs_i  in  1  0 = command byte, 1 = data byte.
REQ-012 req_data_i  in  8  byte to write.
REQ-013 req_ready_o  out  1  controller can accept a byte this cycle.
REQ-014 init_done_o  out  1  power-on init sequence has completed.
REQ-015 lcd_data_o  out  8  LCD data bus.
REQ-016 lcd_rs_o  out  1  LCD register select.
REQ-017 lcd_rw_o  out  1  LCD read/write, held at 0 (write only).
REQ-018 lcd_en_o  out  1  LCD enable strobe.
REQ-019 lcd_on_o  out  1  LCD power enable.

Function
REQ-020 The FSM SHALL have these states: PWRUP, INIT_LOAD, SETUP, PULSE, HOLD, WAIT, IDLE.
REQ-021 PWRUP SHALL count POWERUP_CYC cycles and then go to INIT_LOAD.
REQ-022 INIT_LOAD SHALL take an internal 4-entry ROM value (index 0..3 = 0x38, 0x0C, 0x01, 0x06, rs=0) into the write engine and go to SETUP; INIT_LOAD takes zero cycles, so the load and the move to SETUP happen on PWRUP exit or on WAIT exit.
REQ-023 Write engine: SETUP SHALL hold EN=0 for SETUP_CYC cycles, PULSE SHALL hold EN=1 for EN_CYC cycles, HOLD SHALL hold EN=0 for HOLD_CYC cycles, and WAIT SHALL hold EN=0 for CMD_CYC cycles, or CLR_CYC cycles when rs=0 and the byte is 0x01 or 0x02.
REQ-024 On WAIT exit during init: if the ROM index is below 3, the index SHALL increment and the next ROM byte SHALL load; otherwise init_done_o SHALL be set to 1 and the FSM SHALL go to IDLE.
REQ-025 req_ready_o SHALL be 1 only in IDLE with init_done_o=1, as a registered output.
REQ-026 A request SHALL be accepted on the edge where req_valid_i and req_ready_o are both 1; that edge latches req_rs_i and req_data_i, drives the latched values on lcd_rs_o and lcd_data_o, clears req_ready_o, and enters SETUP.
REQ-027 lcd_rs_o and lcd_data_o SHALL stay stable from acceptance until the next acceptance or the next ROM load, including through all of WAIT.
REQ-028 After acceptance at edge T, lcd_en_o SHALL be 1 exactly during cycles T+SETUP_CYC+1 .. T+SETUP_CYC+EN_CYC, and req_ready_o SHALL return to 1 at edge T+SETUP_CYC+EN_CYC+HOLD_CYC+WAITn, where WAITn is CMD_CYC or CLR_CYC.
REQ-029 req_valid_i while req_ready_o=0, including during init, SHALL be ignored and SHALL have no side effect.
REQ-030 Back-to-back requests: if valid is held high, the next byte SHALL be accepted on the first edge at which ready is 1; no idle bubble is required.
REQ-031 lcd_rw_o SHALL be 0 at all times.
REQ-032 lcd_on_o SHALL be 1 on every cycle after reset deassertion.
REQ-033 The EN pulse width SHALL never be shortened or extended by any input activity.

Reset
REQ-034 On rst_i=1, the following SHALL be driven at the next edge: state=PWRUP, counters=0, ROM index=0, lcd_en_o=0, lcd_rs_o=0, lcd_rw_o=0, lcd_data_o=0x00, lcd_on_o=0, req_ready_o=0, init_done_o=0.
REQ-035 Reset asserted mid-pulse SHALL drop lcd_en_o at the next edge, discard the pending byte, and restart the full init sequence.
REQ-036 rst_i SHALL take priority over every other input.

Verification (params POWERUP=20, SETUP=2, EN=3, HOLD=2, CMD=10, CLR=30)
REQ-037 Release reset, valid=0 -> four EN pulses, 3 cycles each, carrying data 0x38, 0x0C, 0x01, 0x06 with rs=0; init_done_o and req_ready_o rise 108 cycles after the first edge with rst_i=0.
REQ-038 After init, a one-cycle valid with rs=1, data=0x41 -> rs=1 and data=0x41 appear next cycle; EN is high in cycles T+3..T+5; ready returns at T+17.
REQ-039 Command 0x01 with rs=0 -> ready returns at T+37; a command 0x80 -> ready returns at T+17.
REQ-040 valid held high during init and during WAIT -> no extra EN pulses occur, and the held byte is accepted exactly on the ready edge.
REQ-041 rst_i pulsed while EN=1 in the 0x0C init pulse -> EN=0 next cycle, init_done_o=0, and the sequence restarts from PWRUP with 0x38 first.
REQ-042 Random request stream -> a checker confirms RW is always 0, every EN pulse is exactly 3 cycles, and RS/DATA never change while EN=1 or during SETUP and HOLD.
